// File: rtl/color_sensor_apb_regs.sv
// ---------------------------------------------------------------------------
// color_sensor_apb_regs
//   APB register block for an RGB colour sensor front end.
//
//   Register map (paddr[7:0]; upper address bits are ignored):
//     0x00 CTRL    RW  bit0 EN, bits[15:8] THRESH
//     0x04 STATUS  RO  bit0 VALID, bit1 OVF, bit2 OVER_THR
//     0x08 DATA    RO  {8'h00, R, G, B}
//     0x0C IRQ_EN  RW  bit0 VALID, bit1 OVF, bit2 OVER_THR
//                      (present only when COLOR_REGS_IRQ_EN is defined)
//
//   Optional feature macro: COLOR_REGS_IRQ_EN adds IRQ_EN and irq_o.
//
//   Ports:
//     clk, rst_n          clock (rising edge), async active-low reset
//     paddr .. pslverr    APB slave
//     smp_valid_i         one-cycle sample strobe
//     smp_r/g/b_i         sample channels, qualified by smp_valid_i
//     sensor_en_o         CTRL.EN
//     irq_o               level interrupt (macro only)
//     dbg_state_o         current bus FSM state (IDLE=0, SETUP=1, ACCESS=2)
//
//   Handshake: a transfer is one SETUP-state cycle followed by ACCESS-state
//   cycles; the master holds psel/penable/paddr/pwrite/pwdata stable until
//   it sees pready=1, and the transfer (including any write commit and any
//   read side effect) completes on the rising edge that ends that cycle.
//   Dropping psel at any time abandons the transfer.
// ---------------------------------------------------------------------------
module color_sensor_apb_regs #(
  parameter int APB_AW      = 32,
  parameter int APB_DW      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [APB_AW-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_DW-1:0] pwdata,
  output logic [APB_DW-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              smp_valid_i,
  input  logic [7:0]        smp_r_i,
  input  logic [7:0]        smp_g_i,
  input  logic [7:0]        smp_b_i,
  output logic              sensor_en_o,
`ifdef COLOR_REGS_IRQ_EN
  output logic              irq_o,
`endif
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [APB_DW-1:0] prdata_q, prdata_d;
  logic              err_q, err_d;
  logic              en_q, en_d;
  logic [7:0]        thresh_q, thresh_d;
  logic [23:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              ovr_q, ovr_d;

  logic        hit_ctrl, hit_status, hit_data, hit_irq, bad_access;
  logic [31:0] rd_word;
  logic        done, commit, data_rd_done, status_rd_done, smp_cap, smp_over;

`ifdef COLOR_REGS_IRQ_EN
  logic [2:0] irq_en_q, irq_en_d;
  logic       irq_q, irq_d;
`endif

  // Bits never consumed by the register map.
  logic unused_bits;
  assign unused_bits = ^{paddr, pwdata};

  always_comb begin
    hit_ctrl   = (paddr[7:0] == 8'h00);
    hit_status = (paddr[7:0] == 8'h04);
    hit_data   = (paddr[7:0] == 8'h08);
`ifdef COLOR_REGS_IRQ_EN
    hit_irq    = (paddr[7:0] == 8'h0C);
`else
    hit_irq    = 1'b0;
`endif
    // Unmapped offsets and writes to read-only registers are errors.
    bad_access = !(hit_ctrl | hit_status | hit_data | hit_irq) |
                 (pwrite & (hit_status | hit_data));

    rd_word = 32'h0;
    if (hit_ctrl)   rd_word = {16'h0, thresh_q, 7'h0, en_q};
    if (hit_status) rd_word = {29'h0, ovr_q, ovf_q, valid_q};
    if (hit_data)   rd_word = {8'h00, data_q};
`ifdef COLOR_REGS_IRQ_EN
    if (hit_irq)    rd_word = {29'h0, irq_en_q};
`endif
  end

  // Bus FSM and wait counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prdata_d = prdata_q;
    err_d    = err_q;
    done     = (state_q == ST_ACCESS) && (cnt_q == 4'd0);

    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        cnt_d = 4'(WAIT_STATES);
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (penable) begin
          state_d = ST_ACCESS;
          // Read data is snapshotted here so it stays stable while waiting.
          prdata_d        = '0;
          prdata_d[31:0]  = (pwrite || bad_access) ? 32'h0 : rd_word;
          err_d           = bad_access;
        end
      end
      ST_ACCESS: begin
        if (!psel || done) begin
          state_d = ST_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pready      = done;
  assign pslverr     = (state_q == ST_ACCESS) ? (done & err_q) : 1'b0;
  assign prdata      = (state_q == ST_ACCESS) ? prdata_q : '0;
  assign sensor_en_o = en_q;
  assign dbg_state_o = state_q;

  // Register updates and sample capture.
  always_comb begin
    en_d     = en_q;
    thresh_d = thresh_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    ovr_d    = ovr_q;
`ifdef COLOR_REGS_IRQ_EN
    irq_en_d = irq_en_q;
`endif

    commit         = done && psel && penable && pwrite && !err_q;
    data_rd_done   = done && psel && penable && !pwrite && !err_q && hit_data;
    status_rd_done = done && psel && penable && !pwrite && !err_q && hit_status;
    smp_cap        = smp_valid_i && en_q;
    smp_over       = (smp_r_i > thresh_q) || (smp_g_i > thresh_q) ||
                     (smp_b_i > thresh_q);

    if (commit && hit_ctrl) begin
      en_d     = pwdata[0];
      thresh_d = pwdata[15:8];
    end
`ifdef COLOR_REGS_IRQ_EN
    if (commit && hit_irq) irq_en_d = pwdata[2:0];
`endif

    if (data_rd_done)   valid_d = 1'b0;
    if (status_rd_done) ovf_d   = 1'b0;

    if (smp_cap) begin
      data_d  = {smp_r_i, smp_g_i, smp_b_i};
      valid_d = 1'b1;
      ovr_d   = smp_over;
      // A sample landing on the completing DATA read replaces, not overruns.
      if (valid_q && !data_rd_done) ovf_d = 1'b1;
    end
  end

`ifdef COLOR_REGS_IRQ_EN
  assign irq_d = |({ovr_q, ovf_q, valid_q} & irq_en_q);
  assign irq_o = irq_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      prdata_q <= '0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
      thresh_q <= 8'h00;
      data_q   <= 24'h0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef COLOR_REGS_IRQ_EN
      irq_en_q <= 3'b0;
      irq_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prdata_q <= prdata_d;
      err_q    <= err_d;
      en_q     <= en_d;
      thresh_q <= thresh_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      ovr_q    <= ovr_d;
`ifdef COLOR_REGS_IRQ_EN
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
`endif
    end
  end

endmodule

// File: tb/tb_color_sensor_apb_regs.sv
// ---------------------------------------------------------------------------
// tb_color_sensor_apb_regs
//   Self-checking bench for color_sensor_apb_regs with WAIT_STATES = 2.
//   A vector table drives APB transfers and sensor samples; expected
//   {check_data, pslverr, prdata} entries are queued when a transfer is
//   issued and compared when pready is observed. Hand-written sequences
//   cover the sample-during-read and reset-during-access corner cases.
// ---------------------------------------------------------------------------
module tb_color_sensor_apb_regs;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        smp_valid = 1'b0;
  logic [7:0]  smp_r = '0, smp_g = '0, smp_b = '0;
  logic        sensor_en;
  logic [1:0]  dbg_state;
`ifdef COLOR_REGS_IRQ_EN
  logic        irq;
`endif

  // Clock / reset
  always #5 clk = ~clk;

  color_sensor_apb_regs #(.APB_AW(32), .APB_DW(32), .WAIT_STATES(WS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .paddr       (paddr),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .smp_valid_i (smp_valid),
    .smp_r_i     (smp_r),
    .smp_g_i     (smp_g),
    .smp_b_i     (smp_b),
    .sensor_en_o (sensor_en),
`ifdef COLOR_REGS_IRQ_EN
    .irq_o       (irq),
`endif
    .dbg_state_o (dbg_state)
  );

  // Scoreboard
  localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_SMP = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] wdata;     // write data, or {8'h0, R, G, B} for samples
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [33:0] exp_q[$];    // {check_data, pslverr, prdata}
  int          checks = 0;
  int          errors = 0;
  int          last_waits;
  logic [31:0] unused_rd;
  logic        unused_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] kind, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_data,
                         input logic exp_err);
    vec_t v;
    v.kind = kind; v.addr = addr; v.wdata = wdata;
    v.exp_data = exp_data; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // Driver tasks
  task automatic drive_sample(input logic [23:0] rgb);
    @(negedge clk);
    smp_valid = 1'b1;
    {smp_r, smp_g, smp_b} = rgb;
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  // One APB transfer; pops and checks the scoreboard when pready is seen.
  // If inject is set, a sample strobe is driven in the pready cycle.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit inject,
                          input logic [23:0] rgb,
                          output logic [31:0] rdata, output logic err);
    logic [33:0] exp;
    int waits;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!pready && waits < 40);
    check("pready_seen", {31'h0, pready}, 32'h1);
    last_waits = waits;
    rdata = prdata;
    err   = pslverr;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_underflow actual=empty required=entry");
    end else begin
      exp = exp_q.pop_front();
      check($sformatf("pslverr@%h", addr), {31'h0, err}, {31'h0, exp[32]});
      if (exp[33]) check($sformatf("prdata@%h", addr), rdata, exp[31:0]);
    end
    if (inject) begin
      smp_valid = 1'b1;
      {smp_r, smp_g, smp_b} = rgb;
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; smp_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_pready",  {31'h0, pready},  32'h0);
    check("rst_pslverr", {31'h0, pslverr}, 32'h0);
    check("rst_prdata",  prdata,           32'h0);
    check("rst_en",      {31'h0, sensor_en}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    add_vec(K_WR,  32'h00,  32'h0000_3401, 32'h0, 1'b0);
    add_vec(K_RD,  32'h00,  32'h0,         32'h0000_3401, 1'b0);
    add_vec(K_RD,  32'h100, 32'h0,         32'h0000_3401, 1'b0); // upper bits ignored
    add_vec(K_RD,  32'h04,  32'h0,         32'h0, 1'b0);
    add_vec(K_SMP, 32'h0,   32'h0010_4005, 32'h0, 1'b0);
    add_vec(K_RD,  32'h04,  32'h0,         32'h5, 1'b0);
    add_vec(K_RD,  32'h08,  32'h0,         32'h0010_4005, 1'b0);
    add_vec(K_RD,  32'h04,  32'h0,         32'h4, 1'b0);
    add_vec(K_SMP, 32'h0,   32'h0005_0505, 32'h0, 1'b0);
    add_vec(K_SMP, 32'h0,   32'h0050_4040, 32'h0, 1'b0);
    add_vec(K_RD,  32'h04,  32'h0,         32'h7, 1'b0);
    add_vec(K_RD,  32'h04,  32'h0,         32'h5, 1'b0);
    add_vec(K_RD,  32'h08,  32'h0,         32'h0050_4040, 1'b0);
    add_vec(K_WR,  32'h08,  32'hFFFF_FFFF, 32'h0, 1'b1);
    add_vec(K_RD,  32'h20,  32'h0,         32'h0, 1'b1);
`ifdef COLOR_REGS_IRQ_EN
    add_vec(K_WR,  32'h0C,  32'h0000_0000, 32'h0, 1'b0);
`else
    add_vec(K_WR,  32'h0C,  32'h0000_0007, 32'h0, 1'b1);
    add_vec(K_RD,  32'h0C,  32'h0,         32'h0, 1'b1);
`endif
    add_vec(K_WR,  32'h04,  32'hFFFF_FFFF, 32'h0, 1'b1);
    add_vec(K_RD,  32'h04,  32'h0,         32'h4, 1'b0);
    add_vec(K_RD,  32'h08,  32'h0,         32'h0050_4040, 1'b0);
    add_vec(K_RD,  32'h00,  32'h0,         32'h0000_3401, 1'b0);
    add_vec(K_WR,  32'h00,  32'hFFFF_FF00, 32'h0, 1'b0);       // EN=0, THRESH=FF
    add_vec(K_RD,  32'h00,  32'h0,         32'h0000_FF00, 1'b0);
    add_vec(K_SMP, 32'h0,   32'h0001_0203, 32'h0, 1'b0);       // dropped
    add_vec(K_RD,  32'h08,  32'h0,         32'h0050_4040, 1'b0);
    add_vec(K_RD,  32'h04,  32'h0,         32'h4, 1'b0);
    add_vec(K_WR,  32'h00,  32'h0000_3401, 32'h0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].kind == K_SMP) begin
        drive_sample(vecs[i].wdata[23:0]);
      end else begin
        exp_q.push_back({(vecs[i].kind == K_RD), vecs[i].exp_err, vecs[i].exp_data});
        apb_xfer(vecs[i].kind == K_WR, vecs[i].addr, vecs[i].wdata, 1'b0, 24'h0,
                 unused_rd, unused_err);
        if (i == 0) begin
          check("ws2_access_cycles", last_waits, WS + 1);
          check("en_after_write", {31'h0, sensor_en}, 32'h1);
        end
      end
    end
    check("en_final", {31'h0, sensor_en}, 32'h1);

    // Sample strobe in the pready cycle of a DATA read
    drive_sample(24'h11_22_33);
    exp_q.push_back({1'b1, 1'b0, 32'h0011_2233});
    apb_xfer(1'b0, 32'h08, 32'h0, 1'b1, 24'h01_02_03, unused_rd, unused_err);
    exp_q.push_back({1'b1, 1'b0, 32'h1});
    apb_xfer(1'b0, 32'h04, 32'h0, 1'b0, 24'h0, unused_rd, unused_err);
    exp_q.push_back({1'b1, 1'b0, 32'h0001_0203});
    apb_xfer(1'b0, 32'h08, 32'h0, 1'b0, 24'h0, unused_rd, unused_err);

    // Reset asserted in the completion cycle of a CTRL write
    begin
      int waits;
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h0000_5501;
      @(negedge clk);
      penable = 1'b1;
      waits = 0;
      do begin
        @(negedge clk);
        waits++;
      end while (!pready && waits < 40);
      check("rst_seq_pready_before", {31'h0, pready}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("rst_seq_pready",  {31'h0, pready},    32'h0);
      check("rst_seq_en",      {31'h0, sensor_en}, 32'h0);
      check("rst_seq_state",   {30'h0, dbg_state}, 32'h0);
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    apb_xfer(1'b0, 32'h00, 32'h0, 1'b0, 24'h0, unused_rd, unused_err);
    check("ctrl_read_waits", last_waits, WS + 1);
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    apb_xfer(1'b0, 32'h08, 32'h0, 1'b0, 24'h0, unused_rd, unused_err);

    check("sb_empty", exp_q.size(), 32'h0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/color_sensor_apb_regs.md
COLOR_SENSOR_APB_REGS -- requirements
Module: color_sensor_apb_regs

Interface
REQ-001 SHALL have parameter APB_AW, default 32, APB address width.
REQ-002 SHALL have parameter APB_DW, default 32, APB data width; minimum 32.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0..15, access-phase wait cycles inserted before pready.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have APB slave ports: paddr in APB_AW, psel in 1, penable in 1, pwrite in 1, pwdata in APB_DW, prdata out APB_DW, pready out 1, pslverr out 1.
REQ-007 SHALL have port smp_valid_i  input  1  one-cycle sensor sample strobe.
REQ-008 SHALL have ports smp_r_i, smp_g_i, smp_b_i  input  8 each  sample colour channels, qualified by smp_valid_i.
REQ-009 SHALL have port sensor_en_o  output  1  CTRL.EN, enables the sensor front end.

Function
REQ-010 SHALL decode paddr[7:0] only: 0x00 CTRL (RW), 0x04 STATUS (RO), 0x08 DATA (RO), 0x0C IRQ_EN (RW, macro only); all other offsets are unmapped.
REQ-011 SHALL use CTRL bit0 EN and bits[15:8] THRESH; other bits read 0, writes ignored.
REQ-012 SHALL use STATUS bit0 VALID, bit1 OVF, bit2 OVER_THR; other bits read 0.
REQ-013 SHALL return DATA as {8'h00, R, G, B}.
REQ-014 SHALL implement FSM IDLE -> SETUP (psel & !penable) -> ACCESS (psel & penable) -> IDLE when pready = 1; psel low in any state SHALL return to IDLE.
REQ-015 SHALL load the wait counter with WAIT_STATES in SETUP and decrement it each ACCESS cycle; pready = 1 only in the ACCESS cycle where the counter = 0. WAIT_STATES = 0 SHALL give pready in the first ACCESS cycle.
REQ-016 SHALL hold pready at 0 outside its completion cycle; prdata and pslverr SHALL be 0 outside ACCESS.
REQ-017 SHALL capture read data into prdata at SETUP exit and hold it stable for the whole ACCESS phase.
REQ-018 SHALL assert pslverr with pready for unmapped offsets and for writes to STATUS or DATA; such writes SHALL change no state, and such reads SHALL return 0.
REQ-019 SHALL commit writes only in the pready cycle.
REQ-020 SHALL, on smp_valid_i with EN = 1, load R/G/B into DATA and set VALID; if VALID was already 1, SHALL also set OVF. With EN = 0, samples SHALL be dropped.
REQ-021 SHALL set OVER_THR when a captured sample has R, G or B > THRESH, and SHALL clear it on the next captured sample that does not.
REQ-022 SHALL clear VALID on a completed DATA read, and SHALL clear OVF on a completed STATUS read.
REQ-023 SHALL, when a sample arrives in the same cycle as a completing DATA read, capture the new sample, keep VALID = 1 and leave OVF unchanged.
REQ-024 SHALL leave captured data and flags unchanged when EN is cleared.

Reset
REQ-025 SHALL, with rst_n low, immediately force: FSM to IDLE, wait counter to 0, CTRL to 0, DATA to 0, VALID, OVF and OVER_THR to 0, pready to 0, pslverr to 0, prdata to 0, sensor_en_o to 0, and irq_o to 0.
REQ-026 SHALL abort an in-flight transfer on reset with no register update; the first access after release SHALL begin from IDLE.

Configuration
REQ-027 SHALL, with COLOR_REGS_IRQ_EN defined, add output irq_o (1 bit, level) and the IRQ_EN register at 0x0C (bit0 VALID, bit1 OVF, bit2 OVER_THR).
REQ-028 SHALL, with COLOR_REGS_IRQ_EN defined, drive irq_o as OR(STATUS[2:0] & IRQ_EN[2:0]), registered.
REQ-029 SHALL, without COLOR_REGS_IRQ_EN, have no irq_o port and treat 0x0C as unmapped (pslverr = 1).

Verification
REQ-030 SHALL cover: WAIT_STATES = 2, write 0x0000_3401 to 0x00 -> pready in the 3rd ACCESS cycle, pslverr = 0, sensor_en_o = 1, read 0x00 = 0x0000_3401.
REQ-031 SHALL cover: EN = 1, THRESH = 0x34, sample R = 0x10, G = 0x40, B = 0x05 -> STATUS = 0x5; DATA read = 0x0010_4005; STATUS then = 0x4.
REQ-032 SHALL cover: two samples with no DATA read between them -> STATUS = 0x7; STATUS read clears OVF; next STATUS = 0x5.
REQ-033 SHALL cover: write 0x08, read 0x20, write 0x0C without the macro -> pslverr = 1, prdata = 0, registers unchanged.
REQ-034 SHALL cover: sample strobe in the DATA-read pready cycle -> read returns the old sample; VALID = 1; OVF = 0; DATA holds the new sample.
REQ-035 SHALL cover: rst_n low during ACCESS of a CTRL write -> pready = 0 immediately; CTRL = 0 after release; the next read of 0x00 completes normally.
